// File: rtl/alu8_registered.sv
//------------------------------------------------------------------------------
// Module   : alu8_registered
// Purpose  : 8-bit ripple ALU (AND/OR/ADD/LESS with operand inversion),
//            result and carry-out registered on clk.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu8_registered #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             less,
    input  logic             A_invert,
    input  logic             B_invert,
    input  logic             cin,
    input  logic [1:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam logic [1:0] C_OP_AND  = 2'b00;
    localparam logic [1:0] C_OP_OR   = 2'b01;
    localparam logic [1:0] C_OP_ADD  = 2'b10;
    localparam logic [1:0] C_OP_LESS = 2'b11;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] result_d;
    logic             cout_d;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;

    assign w_a = A_invert ? ~src1 : src1;
    assign w_b = B_invert ? ~src2 : src2;

    // Each loop iteration is one 1-bit slice; carry ripples from bit 0 upward.
    always_comb begin
        w_carry    = '0;
        w_sum      = '0;
        w_carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i]     = w_a[i] ^ w_b[i] ^ w_carry[i];
            w_carry[i+1] = (w_a[i] & w_b[i]) | (w_carry[i] & (w_a[i] ^ w_b[i]));
        end
    end

    always_comb begin
        result_d = '0;
        unique case (operation)
            C_OP_AND:  result_d = w_a & w_b;
            C_OP_OR:   result_d = w_a | w_b;
            C_OP_ADD:  result_d = w_sum;
            C_OP_LESS: result_d = {{(WIDTH-1){1'b0}}, less};
            default:   result_d = '0;
        endcase
    end

    // Carry-out follows the chain for every opcode, not just ADD.
    assign cout_d = w_carry[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_alu8_registered.sv
//------------------------------------------------------------------------------
// Module   : tb_alu8_registered
// Purpose  : Directed self-checking bench for alu8_registered.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu8_registered;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src1;
    logic [7:0] src2;
    logic       less;
    logic       A_invert;
    logic       B_invert;
    logic       cin;
    logic [1:0] operation;
    logic [7:0] result;
    logic       cout;

    int total = 0;
    int bad   = 0;

    alu8_registered #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .src1      (src1),
        .src2      (src2),
        .less      (less),
        .A_invert  (A_invert),
        .B_invert  (B_invert),
        .cin       (cin),
        .operation (operation),
        .result    (result),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b,
                        input logic ai, input logic bi, input logic ci,
                        input logic [1:0] op, input logic ls);
        rst = r; src1 = a; src2 = b; A_invert = ai; B_invert = bi;
        cin = ci; operation = op; less = ls;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp_r, input logic exp_c);
        total++;
        assert (result === exp_r) else begin
            bad++;
            $error("FAIL %s result: observed=%02h expected=%02h", tag, result, exp_r);
        end
        total++;
        assert (cout === exp_c) else begin
            bad++;
            $error("FAIL %s cout: observed=%0b expected=%0b", tag, cout, exp_c);
        end
    endtask

    initial begin
        step(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
        step(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
        check("reset", 8'h00, 1'b0);

        // AND
        step(1'b0, 8'b10010110, 8'b11011011, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check("and1", 8'b10010010, 1'b1);
        step(1'b0, 8'b11110001, 8'b00101110, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check("and2", 8'b00100000, 1'b1);
        step(1'b0, 8'b10100101, 8'b01010101, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check("and3", 8'b00000101, 1'b0);

        // OR
        step(1'b0, 8'b00111010, 8'b11001101, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        check("or1", 8'b11111111, 1'b1);
        step(1'b0, 8'b00101110, 8'b11000101, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        check("or2", 8'b11101111, 1'b0);
        step(1'b0, 8'b11010010, 8'b11110001, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        check("or3", 8'b11110011, 1'b1);

        // ADD
        step(1'b0, 8'h15, 8'hFE, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        check("add1", 8'h13, 1'b1);
        step(1'b0, 8'h6C, 8'h91, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        check("add2", 8'hFD, 1'b0);
        step(1'b0, 8'h53, 8'h95, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        check("add3", 8'hE8, 1'b0);
        step(1'b0, 8'h34, 8'hF6, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        check("add4", 8'h2A, 1'b1);
        step(1'b0, 8'hF0, 8'hB0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
        check("addc1", 8'hA1, 1'b1);
        step(1'b0, 8'h35, 8'h92, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
        check("addc2", 8'hC8, 1'b0);

        // SUB
        step(1'b0, 8'h05, 8'h03, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
        check("sub1", 8'h02, 1'b1);
        step(1'b0, 8'h03, 8'h05, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
        check("sub2", 8'hFE, 1'b0);

        // NOR / NAND: ~0x3C & ~0x0F = 0xC3 & 0xF0 = 0xC0; carry of 0xC3+0xF0 = 1
        step(1'b0, 8'h3C, 8'h0F, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        check("nor", 8'hC0, 1'b1);
        // ~0x3C | ~0x0F = 0xF3
        step(1'b0, 8'h3C, 8'h0F, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
        check("nand", 8'hF3, 1'b1);

        // LESS: carry of 0xFF+0xFF still reported
        step(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1);
        check("less1", 8'h01, 1'b1);
        step(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        check("less0", 8'h00, 1'b1);

        // Reset mid-stream, then resume
        step(1'b0, 8'h15, 8'hFE, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        check("pre_rst", 8'h13, 1'b1);
        step(1'b1, 8'h15, 8'hFE, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        check("mid_rst", 8'h00, 1'b0);
        step(1'b0, 8'h15, 8'hFE, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        check("post_rst", 8'h13, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
